// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: zero-latency hits, one 4-word line fetch per miss
// on memory port 1, saturating hit/miss counters.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | serve hits combinationally; a miss latches the line address
// ST_FETCH | readM1 held high, count edges until data1 is captured
module icache_direct_mapped #(
    parameter int WORD_SIZE   = 16,
    parameter int NUM_LINES   = 4,
    parameter int INDEX_BITS  = 2,
    parameter int MEM_LATENCY = 7
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_read,
    input  logic [WORD_SIZE-1:0]   i_address,
    output logic [WORD_SIZE-1:0]   i_data,
    output logic                   i_ready,
    input  logic                   flush,
    output logic                   readM1,
    output logic [WORD_SIZE-1:0]   address1,
    input  logic [4*WORD_SIZE-1:0] data1,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
);

    localparam int TAG_BITS  = WORD_SIZE - 2 - INDEX_BITS;
    localparam int LINE_BITS = 4 * WORD_SIZE;
    localparam int CNT_BITS  = $clog2(MEM_LATENCY + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [NUM_LINES-1:0]  r_valid;
    logic [TAG_BITS-1:0]   r_tag  [NUM_LINES];
    logic [LINE_BITS-1:0]  r_data [NUM_LINES];
    logic [WORD_SIZE-1:0]  r_line_addr;
    logic [CNT_BITS-1:0]   r_lat_cnt;
    logic [15:0]           r_hit_cnt;
    logic [15:0]           r_miss_cnt;

    logic [1:0]            w_offset;
    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic [INDEX_BITS-1:0] w_fill_index;
    logic [TAG_BITS-1:0]   w_fill_tag;
    logic [LINE_BITS-1:0]  w_line;
    logic [WORD_SIZE-1:0]  w_word;
    logic                  w_hit;
    logic                  w_lookup_hit;
    logic                  w_miss_start;
    logic                  w_fill;

    assign w_offset     = i_address[1:0];
    assign w_index      = i_address[2 +: INDEX_BITS];
    assign w_tag        = i_address[WORD_SIZE-1 -: TAG_BITS];
    assign w_fill_index = r_line_addr[2 +: INDEX_BITS];
    assign w_fill_tag   = r_line_addr[WORD_SIZE-1 -: TAG_BITS];
    assign w_line       = r_data[w_index];

    always_comb begin
        w_word = '0;
        case (w_offset)
            2'd0:    w_word = w_line[0*WORD_SIZE +: WORD_SIZE];
            2'd1:    w_word = w_line[1*WORD_SIZE +: WORD_SIZE];
            2'd2:    w_word = w_line[2*WORD_SIZE +: WORD_SIZE];
            default: w_word = w_line[3*WORD_SIZE +: WORD_SIZE];
        endcase
    end

    assign w_hit        = i_read & r_valid[w_index] & (r_tag[w_index] == w_tag);
    assign w_lookup_hit = (r_state == ST_IDLE) & w_hit;
    assign w_miss_start = (r_state == ST_IDLE) & i_read & ~w_hit;
    // Counter value MEM_LATENCY means this edge is the one the memory presents data1 on.
    assign w_fill       = (r_state == ST_FETCH) & (r_lat_cnt == CNT_BITS'(MEM_LATENCY));

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_miss_start) w_state_nxt = ST_FETCH;
            ST_FETCH: if (w_fill)       w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        readM1  = (r_state == ST_FETCH);
        i_ready = w_lookup_hit;
        i_data  = w_lookup_hit ? w_word : '0;
    end

    assign address1   = r_line_addr;
    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_line_addr <= '0;
            r_lat_cnt   <= '0;
        end else if (w_miss_start) begin
            r_line_addr <= {i_address[WORD_SIZE-1:2], 2'b00};
            r_lat_cnt   <= CNT_BITS'(1);
        end else if (w_fill) begin
            r_lat_cnt   <= '0;
        end else if (r_state == ST_FETCH) begin
            r_lat_cnt   <= r_lat_cnt + 1'b1;
        end
    end

    // The fill assignment comes after the flush clear so the filled line stays valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (flush) begin
                r_valid <= '0;
            end
            if (w_fill) begin
                r_valid[w_fill_index] <= 1'b1;
                r_tag[w_fill_index]   <= w_fill_tag;
                r_data[w_fill_index]  <= data1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_lookup_hit && (r_hit_cnt != 16'hFFFF)) begin
                r_hit_cnt <= r_hit_cnt + 16'd1;
            end
            if (w_miss_start && (r_miss_cnt != 16'hFFFF)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch stage and instruction port 1 of the block-transfer memory.
- Serves 16-bit instruction words to the CPU in the same cycle on a hit.
- On a miss, issues one 4-word (64-bit) line fetch on readM1/address1/data1, waits the memory's fixed latency, fills the line, then serves the word.
- Keeps saturating hit and miss counters for performance evaluation.

Parameters:
WORD_SIZE, 16, instruction word and address width
NUM_LINES, 4, number of cache lines (power of two)
INDEX_BITS, 2, log2(NUM_LINES)
MEM_LATENCY, 7, rising edges from readM1 assertion to the edge at which data1 is captured

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
i_read  input  1  CPU fetch request
i_address  input  16  CPU fetch word address
i_data  output  16  fetched instruction, valid when i_ready=1
i_ready  output  1  hit: i_data valid this cycle
flush  input  1  invalidate all lines (synchronous)
readM1  output  1  memory port-1 read request
address1  output  16  memory port-1 address, always line-aligned ([1:0]=2'b00)
data1  input  64  memory line: word0 [15:0], word1 [31:16], word2 [47:32], word3 [63:48]
hit_count  output  16  saturating hit counter
miss_count  output  16  saturating miss counter

Behaviour:
- One clock, clk. Asynchronous active-low reset on reset_n.
- Reset (async, reset_n=0):
  - All valid bits 0; state IDLE.
  - readM1=0, address1=0, hit_count=0, miss_count=0, internal latency counter 0.
  - i_ready=0 while reset_n=0.
  - Reset mid-FETCH aborts the fetch; no line is written.
- Address split: offset=i_address[1:0], index=i_address[2+INDEX_BITS-1:2], tag=remaining upper bits.
- State IDLE:
  - Hit = i_read & valid[index] & tag match.
  - i_ready=hit, combinational. i_data = word[offset] of line[index], combinational. Zero-latency hit.
  - On i_read & !hit: latch line address {i_address[15:2],2'b00}, increment miss_count, go to FETCH at the next edge.
  - While i_read=0: i_ready=0 and i_data=16'h0.
- State FETCH:
  - readM1=1; address1 holds the latched line address (stable for the whole fetch).
  - Counter starts at 1 on entry and increments each edge.
  - At the MEM_LATENCY-th rising edge after readM1 first went high: write data1 into line[latched index], set its tag and valid bit, drop readM1, return to IDLE.
  - i_ready=0 throughout FETCH.
- Total miss penalty with default parameters: request in cycle 0 -> readM1 high after edge 1 -> capture at edge 8 -> i_ready=1 in cycle 8 (if i_address unchanged).
- readM1 is low for at least one full cycle between consecutive fetches, because IDLE is always visited. This is required since the memory restarts latency only on a rising edge of readM1.
- i_address changing during FETCH does not affect the in-flight fetch. IDLE re-evaluates the current address after the fill.
- Flush:
  - Clears all valid bits at the next edge. In IDLE it forces a miss from the following cycle.
  - Flush during FETCH clears the other lines, but the in-flight fill still completes and leaves its line valid.
  - Flush and fill on the same edge: the fill wins for its line.
- Counters:
  - hit_count increments on each rising edge where i_ready=1.
  - miss_count increments on each IDLE->FETCH transition.
  - Both saturate at 16'hFFFF, with no wrap.
- Replacement: direct-mapped. A fill overwrites the line's previous tag and data unconditionally. No writes from the CPU side; the cache is read-only.
- Memory must be reset and preloaded before reset_n is released.

Test Plan:
- Cold miss: reset, i_read=1, i_address=16'h0023 -> readM1=1 with address1=16'h0020 from cycle 1 through cycle 7, fill at edge 8, i_ready=1 with i_data=16'h6000 in cycle 8; miss_count=1, i_ready=0 in cycles 0-7.
- Spatial hits: after the cold miss, i_address=16'h0020 then 16'h0022 -> zero-latency i_ready=1 with i_data=16'h0000 each; hit_count increments per cycle; readM1 stays 0.
- Second line and conflict: fetch 16'h0024 -> miss, i_data=16'hF01C after 8 cycles. Then 16'h0033 (index 0, new tag) -> miss, i_data=16'h5503, evicting the 0x20 line. Then 16'h0023 -> miss again; miss_count=4.
- Back-to-back misses: 16'h0023 then immediately 16'h0027 -> readM1 observed low for exactly one cycle between the two fetches; second fetch uses address1=16'h0024.
- Flush and reset: flush during FETCH for 16'h0023 -> fill completes, 16'h0023 hits afterward, previously valid line 1 misses. Separately, assert reset_n=0 at cycle 4 of a fetch -> readM1 drops asynchronously, and after release 16'h0023 misses.
- Saturation: force 70000 hit cycles -> hit_count holds 16'hFFFF.
